// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: arms on a start request, enables the capture
// block from the next camera vsync, checks the AXIS video beat framing
// (tuser at start of frame, tlast at end of line), counts good frames and
// resynchronises to vsync whenever a frame is malformed.
module cam_capture_ctrl #(
    parameter int X_RES = 640,
    parameter int Y_RES = 480
) (
    input  logic        i_sysclk,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_mode,
    input  logic        i_vsync,
    input  logic        i_tvalid,
    input  logic        i_tready,
    input  logic        i_tuser,
    input  logic        i_tlast,
    output logic        o_cap_enable,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_err_sticky,
    output logic [15:0] o_frame_count
);

    localparam int PIX_W  = (X_RES > 1) ? $clog2(X_RES) : 1;
    localparam int LINE_W = (Y_RES > 1) ? $clog2(Y_RES) : 1;
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(X_RES - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(Y_RES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACTIVE,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;          // 1 = continuous capture
    logic               stop_q, stop_d;          // stop requested during a frame
    logic               in_frame_q, in_frame_d;  // a vsync has opened the current frame
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               sticky_q, sticky_d;
    logic [15:0]        count_q, count_d;

    logic               vs_meta, vs_sync, vs_prev;
    logic               vs_rise;
    logic               beat;
    logic               beat_bad;
    logic               pix_last;
    logic               line_last;

    // Bring the asynchronous vsync into the clock domain and keep one more
    // stage of history so its rising edge can be detected.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge i_sysclk) begin
        if (!i_resetn) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= i_vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign vs_rise   = vs_sync & ~vs_prev;
    assign beat      = i_tvalid & i_tready;
    assign pix_last  = (pix_q == PIX_LAST);
    assign line_last = (line_q == LINE_LAST);
    // Framing markers must appear exactly where expected: a missing marker is
    // as much a framing fault as a stray one.
    assign beat_bad  = (i_tuser != ((pix_q == '0) && (line_q == '0))) ||
                       (i_tlast != pix_last);

    // State register and all controller bookkeeping.
    always_ff @(posedge i_sysclk) begin
        if (!i_resetn) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            stop_q     <= 1'b0;
            in_frame_q <= 1'b0;
            pix_q      <= '0;
            line_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            stop_q     <= stop_d;
            in_frame_q <= in_frame_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic: sequencing, beat counting, framing checks.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        stop_d     = stop_q;
        in_frame_d = in_frame_q;
        pix_d      = pix_q;
        line_d     = line_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sticky_d   = sticky_q;
        count_d    = count_q;

        unique case (state_q)
            IDLE: begin
                stop_d     = 1'b0;
                in_frame_d = 1'b0;
                pix_d      = '0;
                line_d     = '0;
                // A start together with a stop is treated as contradictory.
                if (i_start && !i_stop) begin
                    state_d  = ARM;
                    mode_d   = i_mode;
                    sticky_d = 1'b0;
                end
            end

            ARM: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    state_d    = ACTIVE;
                    in_frame_d = 1'b1;
                    pix_d      = '0;
                    line_d     = '0;
                end
            end

            ACTIVE: begin
                if (i_stop) begin
                    stop_d = 1'b1;
                end
                if (!in_frame_q) begin
                    // Between frames in continuous mode: wait for the next vsync.
                    if (vs_rise) begin
                        in_frame_d = 1'b1;
                        pix_d      = '0;
                        line_d     = '0;
                    end else if (beat) begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        state_d  = ARM;
                    end else if (stop_q || i_stop) begin
                        state_d = DRAIN;
                    end
                end else if (vs_rise || (beat && beat_bad)) begin
                    // Short frame or broken framing: drop the frame and resync.
                    err_d      = 1'b1;
                    sticky_d   = 1'b1;
                    in_frame_d = 1'b0;
                    pix_d      = '0;
                    line_d     = '0;
                    state_d    = ARM;
                end else if (beat) begin
                    if (pix_last && line_last) begin
                        done_d     = 1'b1;
                        count_d    = count_q + 16'd1;
                        in_frame_d = 1'b0;
                        pix_d      = '0;
                        line_d     = '0;
                        if (!mode_q || stop_q || i_stop) begin
                            state_d = DRAIN;
                        end
                    end else if (pix_last) begin
                        pix_d  = '0;
                        line_d = line_q + LINE_W'(1);
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end

            DRAIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_cap_enable  = (state_q == ACTIVE);
    assign o_busy        = (state_q != IDLE);
    assign o_frame_done  = done_q;
    assign o_frame_err   = err_q;
    assign o_err_sticky  = sticky_q;
    assign o_frame_count = count_q;

endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL have parameter X_RES, default 640, meaning the number of pixels (AXIS beats) per line.
REQ-002 SHALL have parameter Y_RES, default 480, meaning the number of lines per frame.
REQ-003 SHALL have port i_sysclk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_start, input, 1 bit: capture start request, level-sampled.
REQ-006 SHALL have port i_stop, input, 1 bit: stop request, level-sampled.
REQ-007 SHALL have port i_mode, input, 1 bit: 0 = single frame, 1 = continuous, sampled on accepted start.
REQ-008 SHALL have port i_vsync, input, 1 bit: raw camera vsync, asynchronous to i_sysclk.
REQ-009 SHALL have ports i_tvalid, i_tready, i_tuser, i_tlast, input, 1 bit each: monitor taps on the capture block's video AXIS master.
REQ-010 SHALL have port o_cap_enable, output, 1 bit: enable to the capture block.
REQ-011 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have ports o_frame_done and o_frame_err, output, 1 bit each: single-cycle pulses.
REQ-013 SHALL have port o_err_sticky, output, 1 bit: set by any frame error, cleared only by an accepted start or by reset.
REQ-014 SHALL have port o_frame_count, output, 16 bits: count of good frames, wrapping 0xFFFF->0.

Function
REQ-015 SHALL synchronize i_vsync through 2 flops, then register it once more for edge detection; a rising edge is detected 3 cycles after i_vsync rises.
REQ-016 SHALL implement states IDLE, ARM, ACTIVE and DRAIN; o_state is not exported.
REQ-017 IDLE: on i_start=1 with i_stop=0 -> ARM, latch i_mode, clear o_err_sticky; i_start with i_stop simultaneously SHALL be ignored.
REQ-018 ARM: on detected vsync rising edge -> ACTIVE; o_cap_enable SHALL assert in the cycle after the edge is detected; i_stop=1 -> IDLE immediately.
REQ-019 ACTIVE: o_cap_enable=1; a beat is a cycle with i_tvalid and i_tready both 1; pixel counter is ceil(log2 X_RES) bits and line counter is ceil(log2 Y_RES) bits, both 0 on entry.
REQ-020 Each beat SHALL increment the pixel counter; at X_RES-1 it wraps to 0 and increments the line counter.
REQ-021 Beat rules: tuser SHALL be 1 only on pixel 0 of line 0; tlast SHALL be 1 only on pixel X_RES-1; any violation is a frame error.
REQ-022 The last beat of line Y_RES-1 completes the frame: o_frame_done SHALL pulse in the next cycle, o_frame_count increments, and the counters clear.
REQ-023 After frame completion: single mode or stop pending -> DRAIN; continuous mode -> remain in ACTIVE awaiting the next vsync edge, with beats before that edge flagged as errors.
REQ-024 A vsync rising edge in ACTIVE before frame completion (short frame) is a frame error.
REQ-025 On a frame error: o_frame_err SHALL pulse the next cycle, o_err_sticky is set, o_frame_count is unchanged, counters clear, and the state -> ARM (resync).
REQ-026 Multiple errors within one frame SHALL produce only one o_frame_err pulse, because resync occurs on the first.
REQ-027 i_stop in ACTIVE SHALL latch a stop-pending flag; the current frame finishes, then the state -> DRAIN. The flag clears in IDLE.
REQ-028 DRAIN: o_cap_enable=0 and the state -> IDLE after 1 cycle.
REQ-029 i_start SHALL be ignored while o_busy=1.

Reset
REQ-030 With i_resetn=0 at a clock edge: state=IDLE, o_cap_enable=0, o_busy=0, o_frame_done=0, o_frame_err=0, o_err_sticky=0, o_frame_count=0, counters=0, stop-pending=0, and the vsync synchronizer flops=0.
REQ-031 Reset mid-frame SHALL abort immediately with no done or error pulse; o_cap_enable is 0 in the cycle after the reset edge.

Verification (X_RES=4, Y_RES=2)
REQ-032 Single mode: start, vsync pulse, 8 good beats (tuser on beat 0, tlast on beats 3 and 7) -> one o_frame_done, o_frame_count=1, o_cap_enable falls, IDLE.
REQ-033 Continuous mode: 3 frames each preceded by vsync -> o_frame_count=3, o_cap_enable held high throughout, no o_frame_err.
REQ-034 tlast on beat 2 instead of beat 3 -> o_frame_err pulse, o_err_sticky=1, o_frame_count unchanged; next good frame -> o_frame_count increments.
REQ-035 vsync rising after 5 beats -> o_frame_err; a second start clears o_err_sticky.
REQ-036 i_stop asserted at beat 3 in continuous mode -> frame completes (o_frame_done, count+1), then DRAIN and IDLE; i_stop in ARM -> IDLE with no pulses.
REQ-037 i_resetn=0 at beat 5 -> all outputs reach reset values; a restart then captures normally.
